// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory fetch controller:
// memory geometry, FSM state encoding and a load-length validity helper.
package imem_pkg;

  localparam int DATA_W = 20;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;
  // Program lengths run 1..DEPTH, so they need one more bit than an address.
  localparam int LEN_W  = ADDR_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_REQ   = 3'd2,
    ST_WAIT  = 3'd3,
    ST_VALID = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  // A load request is only honoured for lengths 1..DEPTH.
  function automatic logic len_ok(input logic [LEN_W-1:0] len);
    len_ok = (len != {LEN_W{1'b0}}) && (len <= LEN_W'(DEPTH));
  endfunction

endpackage

// File: rtl/imem_fetch_ctrl.sv
// Instruction memory sequencer. Shares the single memory port between the
// host program loader (writes, LOAD) and the fetch stage (reads, RUN), and
// hands fetched words to decode over a valid/ready handshake. Supports PC
// redirects and re-running the loaded program without reloading.
module imem_fetch_ctrl
  import imem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load_start,
  input  logic [LEN_W-1:0]  i_load_len,
  input  logic              i_ld_valid,
  input  logic [DATA_W-1:0] i_ld_data,
  output logic              o_ld_ready,
  input  logic              i_run_start,
  output logic              o_mem_enable,
  output logic              o_mem_read_writenot,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic [ADDR_W-1:0] o_mem_waddr,
  output logic [ADDR_W-1:0] o_mem_raddr,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_fetch_valid,
  input  logic              i_fetch_ready,
  output logic [DATA_W-1:0] o_fetch_instr,
  output logic [ADDR_W-1:0] o_fetch_pc,
  input  logic              i_redirect_valid,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W-1:0]   r_load_cnt;
  logic [LEN_W-1:0]    r_prog_len;
  logic                r_fetch_valid;
  logic [DATA_W-1:0]   r_fetch_instr;
  logic [ADDR_W-1:0]   r_fetch_pc;
  logic                r_done;
  logic                r_err;

  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   w_pc_nxt;
  logic [ADDR_W-1:0]   w_load_cnt_nxt;
  logic [LEN_W-1:0]    w_prog_len_nxt;
  logic                w_fetch_valid_nxt;
  logic [DATA_W-1:0]   w_fetch_instr_nxt;
  logic [ADDR_W-1:0]   w_fetch_pc_nxt;
  logic                w_err_nxt;

  logic                w_load_go;
  logic                w_load_last;
  logic                w_pc_last;
  logic                w_redir_hit;
  state_t              w_redir_state;
  logic [ADDR_W-1:0]   w_redir_pc;
  logic                w_redir_err;

  // A load request with an out-of-range length behaves as if absent.
  assign w_load_go   = i_load_start & len_ok(i_load_len);
  // The word being accepted is the final one of the program.
  assign w_load_last = ({1'b0, r_load_cnt} == (r_prog_len - LEN_ONE));
  // The instruction now in VALID is the final one of the program.
  assign w_pc_last   = (({1'b0, r_pc} + LEN_ONE) == r_prog_len);

  // Redirect outcome: in-range targets restart fetching there, anything
  // else latches the error and parks the controller in DONE.
  assign w_redir_hit   = ({1'b0, i_redirect_pc} < r_prog_len);
  assign w_redir_state = w_redir_hit ? ST_REQ : ST_DONE;
  assign w_redir_pc    = w_redir_hit ? i_redirect_pc : r_pc;
  assign w_redir_err   = r_err | ~w_redir_hit;

  // Next-state logic plus memory-port / loader / busy outputs decoded from state.
  always_comb begin
    w_state_nxt         = r_state;
    w_pc_nxt            = r_pc;
    w_load_cnt_nxt      = r_load_cnt;
    w_prog_len_nxt      = r_prog_len;
    w_fetch_valid_nxt   = r_fetch_valid;
    w_fetch_instr_nxt   = r_fetch_instr;
    w_fetch_pc_nxt      = r_fetch_pc;
    w_err_nxt           = r_err;
    o_ld_ready          = 1'b0;
    o_mem_enable        = 1'b0;
    o_mem_read_writenot = 1'b0;
    o_mem_wdata         = {DATA_W{1'b0}};
    o_mem_waddr         = {ADDR_W{1'b0}};
    o_mem_raddr         = {ADDR_W{1'b0}};
    o_busy              = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_load_go) begin
          w_prog_len_nxt = i_load_len;
          w_load_cnt_nxt = {ADDR_W{1'b0}};
          w_err_nxt      = 1'b0;
          w_state_nxt    = ST_LOAD;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end

      ST_LOAD: begin
        o_busy     = 1'b1;
        o_ld_ready = 1'b1;
        if (i_ld_valid) begin
          o_mem_enable = 1'b1;
          o_mem_waddr  = r_load_cnt;
          o_mem_wdata  = i_ld_data;
          if (w_load_last) begin
            // Counter stays at prog_len-1 so it never runs past the program.
            w_pc_nxt    = {ADDR_W{1'b0}};
            w_state_nxt = ST_REQ;
          end else begin
            w_load_cnt_nxt = r_load_cnt + ADDR_ONE;
          end
        end else begin
          o_mem_enable = 1'b0;
        end
      end

      ST_REQ: begin
        o_busy              = 1'b1;
        o_mem_enable        = 1'b1;
        o_mem_read_writenot = 1'b1;
        o_mem_raddr         = r_pc;
        if (i_redirect_valid) begin
          w_state_nxt       = w_redir_state;
          w_pc_nxt          = w_redir_pc;
          w_err_nxt         = w_redir_err;
          w_fetch_valid_nxt = 1'b0;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end

      ST_WAIT: begin
        o_busy = 1'b1;
        if (i_redirect_valid) begin
          // The read returning this cycle is stale: drop it.
          w_state_nxt       = w_redir_state;
          w_pc_nxt          = w_redir_pc;
          w_err_nxt         = w_redir_err;
          w_fetch_valid_nxt = 1'b0;
        end else begin
          w_fetch_instr_nxt = i_mem_rdata;
          w_fetch_pc_nxt    = r_pc;
          w_fetch_valid_nxt = 1'b1;
          w_state_nxt       = ST_VALID;
        end
      end

      ST_VALID: begin
        o_busy = 1'b1;
        if (i_redirect_valid) begin
          w_state_nxt       = w_redir_state;
          w_pc_nxt          = w_redir_pc;
          w_err_nxt         = w_redir_err;
          w_fetch_valid_nxt = 1'b0;
        end else if (i_fetch_ready) begin
          w_fetch_valid_nxt = 1'b0;
          if (w_pc_last) begin
            // pc holds at the last address so a full-depth program never wraps.
            w_state_nxt = ST_DONE;
          end else begin
            w_pc_nxt    = r_pc + ADDR_ONE;
            w_state_nxt = ST_REQ;
          end
        end else begin
          w_state_nxt = ST_VALID;
        end
      end

      ST_DONE: begin
        if (w_load_go) begin
          w_prog_len_nxt = i_load_len;
          w_load_cnt_nxt = {ADDR_W{1'b0}};
          w_err_nxt      = 1'b0;
          w_state_nxt    = ST_LOAD;
        end else if (i_redirect_valid) begin
          w_state_nxt = w_redir_state;
          w_pc_nxt    = w_redir_pc;
          w_err_nxt   = w_redir_err;
        end else if (i_run_start) begin
          w_pc_nxt    = {ADDR_W{1'b0}};
          w_state_nxt = ST_REQ;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end

      default: begin
        w_state_nxt       = ST_IDLE;
        w_fetch_valid_nxt = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset returns everything to IDLE at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_pc          <= {ADDR_W{1'b0}};
      r_load_cnt    <= {ADDR_W{1'b0}};
      r_prog_len    <= {LEN_W{1'b0}};
      r_fetch_valid <= 1'b0;
      r_fetch_instr <= {DATA_W{1'b0}};
      r_fetch_pc    <= {ADDR_W{1'b0}};
      r_done        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_load_cnt    <= w_load_cnt_nxt;
      r_prog_len    <= w_prog_len_nxt;
      r_fetch_valid <= w_fetch_valid_nxt;
      r_fetch_instr <= w_fetch_instr_nxt;
      r_fetch_pc    <= w_fetch_pc_nxt;
      r_done        <= (w_state_nxt == ST_DONE);
      r_err         <= w_err_nxt;
    end
  end

  assign o_fetch_valid = r_fetch_valid;
  assign o_fetch_instr = r_fetch_instr;
  assign o_fetch_pc    = r_fetch_pc;
  assign o_done        = r_done;
  assign o_err         = r_err;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl. The bench owns the instruction
// memory, keeps the program it loaded, and predicts the fetched stream as a
// simple program-counter walk over that array.
module tb_imem_fetch_ctrl;
  import imem_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              load_start = 1'b0;
  logic [LEN_W-1:0]  load_len = '0;
  logic              ld_valid = 1'b0;
  logic [DATA_W-1:0] ld_data = '0;
  logic              ld_ready;
  logic              run_start = 1'b0;
  logic              mem_enable;
  logic              mem_rw;
  logic [DATA_W-1:0] mem_wdata;
  logic [ADDR_W-1:0] mem_waddr;
  logic [ADDR_W-1:0] mem_raddr;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              fetch_valid;
  logic              fetch_ready = 1'b0;
  logic [DATA_W-1:0] fetch_instr;
  logic [ADDR_W-1:0] fetch_pc;
  logic              redirect_valid = 1'b0;
  logic [ADDR_W-1:0] redirect_pc = '0;
  logic              busy;
  logic              done;
  logic              err;

  logic [DATA_W-1:0] mem_model [DEPTH];
  logic [DATA_W-1:0] prog [DEPTH];
  int n_checks = 0;
  int n_fail   = 0;

  imem_fetch_ctrl dut (
    .clk(clk), .rst(rst),
    .i_load_start(load_start), .i_load_len(load_len),
    .i_ld_valid(ld_valid), .i_ld_data(ld_data), .o_ld_ready(ld_ready),
    .i_run_start(run_start),
    .o_mem_enable(mem_enable), .o_mem_read_writenot(mem_rw),
    .o_mem_wdata(mem_wdata), .o_mem_waddr(mem_waddr), .o_mem_raddr(mem_raddr),
    .i_mem_rdata(mem_rdata),
    .o_fetch_valid(fetch_valid), .i_fetch_ready(fetch_ready),
    .o_fetch_instr(fetch_instr), .o_fetch_pc(fetch_pc),
    .i_redirect_valid(redirect_valid), .i_redirect_pc(redirect_pc),
    .o_busy(busy), .o_done(done), .o_err(err)
  );

  always #5 clk = ~clk;

  // Synchronous memory: write on enable & ~rw, read data one cycle after request.
  always @(posedge clk) begin
    if (mem_enable && !mem_rw) mem_model[mem_waddr] <= mem_wdata;
    if (mem_enable && mem_rw)  mem_rdata <= mem_model[mem_raddr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ld_ready"}, {31'd0, ld_ready}, 32'd0);
    check({tag, "_mem_ctl"}, {30'd0, mem_enable, mem_rw}, 32'd0);
    check({tag, "_mem_wdata"}, {12'd0, mem_wdata}, 32'd0);
    check({tag, "_mem_addr"}, {22'd0, mem_waddr, mem_raddr}, 32'd0);
    check({tag, "_fetch"}, {6'd0, fetch_valid, fetch_pc, fetch_instr}, 32'd0);
    check({tag, "_status"}, {29'd0, busy, done, err}, 32'd0);
  endtask

  // Load prog[0..len-1]; optional random bubbles on ld_valid.
  task automatic load_prog(input int len, input bit gaps);
    int cnt = 0;
    int budget = 0;
    load_start = 1'b1;
    load_len   = LEN_W'(len);
    tick();
    load_start = 1'b0;
    check("load_busy", {31'd0, busy}, 32'd1);
    check("load_ld_ready", {31'd0, ld_ready}, 32'd1);
    check("load_err_clear", {31'd0, err}, 32'd0);
    while (cnt < len && budget < 400) begin
      ld_valid = gaps ? ($urandom_range(3) != 0) : 1'b1;
      ld_data  = prog[cnt];
      #1;
      if (ld_valid) begin
        check("wr_en", {30'd0, mem_enable, mem_rw}, 32'd2);
        check("wr_addr", {27'd0, mem_waddr}, cnt);
        check("wr_data", {12'd0, mem_wdata}, {12'd0, prog[cnt]});
      end else begin
        check("wr_bubble_en", {31'd0, mem_enable}, 32'd0);
      end
      tick();
      if (ld_valid) cnt++;
      budget++;
    end
    ld_valid = 1'b0;
    ld_data  = '0;
    check("load_words", cnt, len);
    check("post_load_ld_ready", {31'd0, ld_ready}, 32'd0);
    check("post_load_req", {30'd0, mem_enable, mem_rw}, 32'd3);
    check("post_load_raddr", {27'd0, mem_raddr}, 32'd0);
  endtask

  task automatic run_until_done(input string tag);
    int cyc = 0;
    fetch_ready = 1'b1;
    while (!done && cyc < 300) begin
      tick();
      cyc++;
    end
    check({tag, "_done"}, {30'd0, done, busy}, 32'd2);
  endtask

  // Run from REQ at pc 0 with random stalls (and optionally in-range
  // redirects); every handshake is compared against a plain pc walk.
  task automatic run_prog(input int len, input int stop_pc, input bit redir);
    int exp_pc = 0;
    int cyc = 0;
    bit stopped = 1'b0;
    while (!done && cyc < 3000 && !stopped) begin
      if (stop_pc >= 0 && fetch_valid && exp_pc == stop_pc) begin
        stopped = 1'b1;
        check("stop_pc", {27'd0, fetch_pc}, exp_pc);
        check("stop_instr", {12'd0, fetch_instr}, {12'd0, prog[exp_pc]});
      end else begin
        fetch_ready    = ($urandom_range(3) != 0);
        redirect_valid = redir && busy && ($urandom_range(15) == 0);
        redirect_pc    = ADDR_W'($urandom_range(len - 1));
        if (redirect_valid) begin
          exp_pc = int'(redirect_pc);
        end else if (fetch_valid && fetch_ready) begin
          check("hs_pc", {27'd0, fetch_pc}, exp_pc);
          check("hs_instr", {12'd0, fetch_instr}, {12'd0, prog[exp_pc]});
          exp_pc++;
        end
        tick();
        cyc++;
      end
    end
    redirect_valid = 1'b0;
    if (stop_pc < 0) begin
      check("run_done", {30'd0, done, busy}, 32'd2);
      check("run_count", exp_pc, len);
    end else begin
      check("run_reached_stop", {31'd0, stopped}, 32'd1);
    end
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Three-word load with ld_valid held high
    prog[0] = 20'h00011;
    prog[1] = 20'h00022;
    prog[2] = 20'h00033;
    load_prog(3, 1'b0);

    // Back-to-back run: one instruction every three cycles
    fetch_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("run_wait_valid", {31'd0, fetch_valid}, 32'd0);
      tick();
      check("run_valid", {31'd0, fetch_valid}, 32'd1);
      check("run_pc", {27'd0, fetch_pc}, k);
      check("run_instr", {12'd0, fetch_instr}, {12'd0, prog[k]});
      tick();
      if (k < 2) check("run_next_raddr", {26'd0, mem_enable, mem_raddr}, 32'h20 | (k + 1));
    end
    check("run_end", {29'd0, done, busy, fetch_valid}, 32'd4);

    // Stall 4 cycles in VALID at pc 1
    run_start = 1'b1;
    tick();
    run_start = 1'b0;
    check("rerun_raddr", {26'd0, mem_enable, mem_raddr}, 32'h20);
    repeat (4) tick();
    fetch_ready = 1'b0;
    tick();
    check("stall_entry", {6'd0, fetch_valid, fetch_pc, fetch_instr}, {6'd0, 1'b1, 5'd1, 20'h00022});
    for (int s = 0; s < 4; s++) begin
      tick();
      check("stall_hold", {6'd0, fetch_valid, fetch_pc, fetch_instr}, {6'd0, 1'b1, 5'd1, 20'h00022});
      check("stall_no_mem", {31'd0, mem_enable}, 32'd0);
    end
    fetch_ready = 1'b1;
    tick();
    check("stall_release_raddr", {26'd0, mem_enable, mem_raddr}, 32'h22);
    run_until_done("stall");

    // Redirect to pc 0 during WAIT at pc 2
    run_start = 1'b1;
    tick();
    run_start = 1'b0;
    repeat (7) tick();
    check("redir_at_wait", {31'd0, fetch_valid}, 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 5'd0;
    tick();
    redirect_valid = 1'b0;
    check("redir_req", {25'd0, fetch_valid, mem_enable, mem_raddr}, 32'h20);
    tick();
    check("redir_wait_valid", {31'd0, fetch_valid}, 32'd0);
    tick();
    check("redir_deliver", {6'd0, fetch_valid, fetch_pc, fetch_instr}, {6'd0, 1'b1, 5'd0, 20'h00011});
    run_until_done("redir");

    // Out-of-range redirect sets err; run_start keeps it; load_start clears it
    run_start = 1'b1;
    tick();
    run_start = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 5'd5;
    tick();
    redirect_valid = 1'b0;
    check("oor_status", {28'd0, fetch_valid, busy, done, err}, 32'd3);
    run_start = 1'b1;
    tick();
    run_start = 1'b0;
    check("oor_rerun", {25'd0, err, mem_enable, mem_raddr}, 32'h60);
    tick();
    tick();
    check("oor_rerun_deliver", {5'd0, err, fetch_valid, fetch_pc, fetch_instr}, {5'd0, 1'b1, 1'b1, 5'd0, 20'h00011});
    run_until_done("oor");
    check("oor_err_sticky", {31'd0, err}, 32'd1);

    // Full-depth load (clears err), then asynchronous reset mid-run at pc 10
    for (int i = 0; i < DEPTH; i++) prog[i] = DATA_W'($urandom);
    load_prog(DEPTH, 1'b1);
    run_prog(DEPTH, 10, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_busy", {31'd0, busy}, 32'd0);

    // Illegal load lengths are ignored in IDLE
    load_start = 1'b1;
    load_len   = '0;
    tick();
    check("len0_ignored", {30'd0, busy, ld_ready}, 32'd0);
    load_len = LEN_W'(DEPTH + 1);
    tick();
    load_start = 1'b0;
    check("len33_ignored", {30'd0, busy, ld_ready}, 32'd0);

    // Randomised programs with stalls and redirects, then a re-run without reload
    for (int p = 0; p < 4; p++) begin
      int len;
      len = (p == 0) ? DEPTH : int'($urandom_range(DEPTH, 1));
      for (int i = 0; i < DEPTH; i++) prog[i] = DATA_W'($urandom);
      load_prog(len, 1'b1);
      run_prog(len, -1, 1'b1);
      check("rand_err", {31'd0, err}, 32'd0);
      run_start = 1'b1;
      tick();
      run_start = 1'b0;
      run_prog(len, -1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
- Sequences the 32 x 20-bit instruction memory for the mini-core.
- Owns the memory's single enable/read_writenot port and shares it between two users: a host program loader (write side, LOAD phase) and the core's fetch stage (read side, RUN phase).
- Presents fetched instructions to decode with a valid/ready handshake.
- Supports PC redirect (branch/jump) and re-run without reload.

Parameters:
- DATA_W, 20, instruction width.
- ADDR_W, 5, memory address width.
- DEPTH, 32, number of memory words (2**ADDR_W).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- load_start  in  1  begin program load; sampled in IDLE/DONE only
- load_len  in  ADDR_W+1  words to load (1..DEPTH); captured on load_start
- ld_valid  in  1  loader word valid
- ld_data  in  DATA_W  loader word
- ld_ready  out  1  controller accepts a loader word
- run_start  in  1  restart execution from PC 0; sampled in DONE only
- mem_enable  out  1  to memory enable
- mem_read_writenot  out  1  1 = read, 0 = write
- mem_wdata  out  DATA_W  memory write data
- mem_waddr  out  ADDR_W  memory write address
- mem_raddr  out  ADDR_W  memory read address
- mem_rdata  in  DATA_W  memory read data, valid on the cycle after a read request
- fetch_valid  out  1  instr/pc valid to decode
- fetch_ready  in  1  decode accepts
- fetch_instr  out  DATA_W  fetched instruction (registered)
- fetch_pc  out  ADDR_W  address of fetch_instr
- redirect_valid  in  1  PC redirect request
- redirect_pc  in  ADDR_W  redirect target
- busy  out  1  state is LOAD, REQ, WAIT or VALID
- done  out  1  state is DONE
- err  out  1  sticky: a redirect targeted an address >= prog_len

Behaviour:
- Reset (async):
  - state = IDLE; pc, load_cnt, prog_len = 0.
  - All outputs 0, including fetch_instr, err, mem_* and ld_ready.
- Outputs registered: fetch_*, done, err.
- Outputs combinational from state: mem_*, ld_ready, busy.
- IDLE:
  - load_start with load_len in 1..DEPTH: capture prog_len, load_cnt = 0, go to LOAD.
  - load_len of 0 or > DEPTH: ignored, stay in IDLE.
- LOAD:
  - ld_ready = 1.
  - On ld_valid & ld_ready, same cycle: mem_enable = 1, mem_read_writenot = 0, mem_waddr = load_cnt, mem_wdata = ld_data; then load_cnt++.
  - When the accepted word has load_cnt == prog_len-1: pc = 0, go to REQ.
  - ld_valid low: mem_enable = 0, no write.
- REQ: mem_enable = 1, mem_read_writenot = 1, mem_raddr = pc; go to WAIT.
- WAIT: capture mem_rdata into fetch_instr, fetch_pc = pc, fetch_valid = 1; go to VALID.
- VALID:
  - Hold fetch_valid, fetch_instr and fetch_pc stable until fetch_ready.
  - On handshake: fetch_valid = 0 next cycle and pc++.
  - If pc+1 == prog_len, go to DONE; otherwise go to REQ.
  - Latency: one instruction per 3 cycles minimum (REQ, WAIT, VALID).
- DONE:
  - done = 1, mem_enable = 0.
  - run_start: pc = 0, go to REQ.
  - load_start: behaves as in IDLE.
  - If both are asserted, load_start wins.
- Redirect:
  - Applies in REQ, WAIT, VALID and DONE, and has priority over the handshake.
  - The in-flight read is discarded and fetch_valid = 0 next cycle.
  - redirect_pc < prog_len: pc = redirect_pc, go to REQ.
  - Otherwise: err = 1, go to DONE.
  - Ignored in IDLE and LOAD.
- Memory port usage: mem_enable is never asserted in IDLE, WAIT, VALID or DONE.
- Wrap-around: pc and load_cnt never exceed prog_len-1; a program of DEPTH words ends at pc 31 with no wrap to 0.
- Ignored inputs: load_start and run_start are ignored while busy.
- Clearing err: err clears only on reset or on an accepted load_start.
- Reset mid-operation: immediate return to IDLE; memory contents are not cleared by this block.

Decomposition:
- Shared package imem_pkg holds:
  - state encoding (IDLE, LOAD, REQ, WAIT, VALID, DONE);
  - DATA_W and ADDR_W constants;
  - DEPTH.
- No sub-module: a single FSM plus the pc, load_cnt and prog_len registers.

Test Plan:
- Load 3 words (0x00011, 0x00022, 0x00033) with ld_valid held high -> three write cycles at waddr 0,1,2; ld_ready drops; REQ at raddr 0 on the next cycle.
- Run with fetch_ready = 1 -> fetch (pc, instr) = (0, 0x00011), (1, 0x00022), (2, 0x00033), each 3 cycles apart; then done = 1, busy = 0.
- fetch_ready low for 4 cycles in VALID at pc 1 -> fetch_instr stays 0x00022, no new mem read, pc does not advance.
- Redirect to pc 0 during WAIT at pc 2 -> fetch_valid stays 0, next REQ raddr = 0, next delivered instr = 0x00011.
- Redirect to pc 5 with prog_len = 3 -> err = 1, done = 1; run_start restarts at pc 0 with err still 1; a new load_start clears err.
- Load of 32 words, then rst asserted mid-RUN at pc 10 -> all outputs 0 asynchronously, state IDLE; load_len = 0 in IDLE -> ignored, busy stays 0.
